// File: rtl/dsi_line_packetizer.sv
// dsi_line_packetizer: wraps a framed pixel-word stream into DSI packets,
// one VSS short packet per frame plus one long packet (header, payload,
// checksum footer) per video line.
//
// Ports:
//   clk, rst_n        clock; asynchronous active-low reset
//   in_data[31:0]     packed pixel bytes, byte0 = [7:0] goes out first
//   in_valid/in_ready upstream handshake
//   in_sop/in_eop     first / last word of a frame
//   out_data[31:0]    DSI packet word
//   out_valid/out_ready downstream handshake
//   out_sop           marks the VSS word that opens a frame
//   out_eop           marks the footer that closes a frame
//   err_short_line    one-cycle pulse when a frame ends mid-line
//
// Build option: define DSI_LINE_PKT_CRC_EN to compute the footer CRC-16
// (reflected 0x8408, init 0xFFFF); otherwise the footer checksum is 16'h0000.
module dsi_line_packetizer #(
    parameter int unsigned LINE_BYTES = 1440,
    parameter logic [7:0]  DATA_TYPE  = 8'h3E,
    parameter logic [1:0]  VCHAN      = 2'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        in_sop,
    input  logic        in_eop,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    output logic        out_sop,
    output logic        out_eop,
    input  logic        out_ready,
    output logic        err_short_line
);

    typedef enum logic [2:0] {IDLE, VSS, HDR, PAYLOAD, PAD, FOOT} state_t;

    // Hamming parity masks of the DSI header ECC, one per parity bit P0..P5.
    function automatic logic [7:0] hdr_ecc(input logic [23:0] d);
        return {2'b00, ^(d & 24'hEFFC00), ^(d & 24'hDF03F0), ^(d & 24'hB8E38E),
                ^(d & 24'h749A6D), ^(d & 24'hF2555B), ^(d & 24'hF12CB7)};
    endfunction

    localparam logic [11:0] LAST_WORD = 12'(LINE_BYTES / 4 - 1);
    localparam logic [23:0] VSS_HDR   = {16'h0000, VCHAN, 6'h01};
    localparam logic [23:0] LINE_HDR  = {16'(LINE_BYTES), VCHAN, DATA_TYPE[5:0]};
    localparam logic [31:0] VSS_WORD  = {hdr_ecc(VSS_HDR), VSS_HDR};
    localparam logic [31:0] HDR_WORD  = {hdr_ecc(LINE_HDR), LINE_HDR};

    state_t      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic        frame_end_q, frame_end_d;
    logic [31:0] held_q, held_d;
    logic        held_eop_q, held_eop_d;
    logic        first_q, first_d;
    logic        err_q, err_d;
    logic        run_q;
    logic        src_eop;
    logic [15:0] checksum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            frame_end_q <= 1'b0;
            held_q      <= '0;
            held_eop_q  <= 1'b0;
            first_q     <= 1'b0;
            err_q       <= 1'b0;
            run_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_end_q <= frame_end_d;
            held_q      <= held_d;
            held_eop_q  <= held_eop_d;
            first_q     <= first_d;
            err_q       <= err_d;
            run_q       <= 1'b1;
        end
    end

    // first_q: the sop word captured in IDLE is still owed as the first
    // payload word, so the upstream port stays closed until it has gone out.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        frame_end_d = frame_end_q;
        held_d      = held_q;
        held_eop_d  = held_eop_q;
        first_d     = first_q;
        err_d       = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_sop     = 1'b0;
        out_eop     = 1'b0;
        out_data    = '0;
        src_eop     = first_q ? held_eop_q : in_eop;
        case (state_q)
            IDLE: begin
                in_ready = run_q;
                if (run_q && in_valid && in_sop) begin
                    held_d      = in_data;
                    held_eop_d  = in_eop;
                    first_d     = 1'b1;
                    cnt_d       = '0;
                    frame_end_d = 1'b0;
                    state_d     = VSS;
                end
            end
            VSS: begin
                out_valid = 1'b1;
                out_sop   = 1'b1;
                out_data  = VSS_WORD;
                if (out_ready) state_d = HDR;
            end
            HDR: begin
                out_valid = 1'b1;
                out_data  = HDR_WORD;
                if (out_ready) state_d = PAYLOAD;
            end
            PAYLOAD: begin
                in_ready  = out_ready & ~first_q;
                out_valid = first_q | in_valid;
                out_data  = first_q ? held_q : in_data;
                if (out_valid && out_ready) begin
                    first_d = 1'b0;
                    cnt_d   = cnt_q + 12'd1;
                    if (cnt_q == LAST_WORD) begin
                        state_d     = FOOT;
                        frame_end_d = src_eop;
                    end else if (src_eop) begin
                        state_d     = PAD;
                        frame_end_d = 1'b1;
                        err_d       = 1'b1;
                    end
                end
            end
            PAD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    cnt_d = cnt_q + 12'd1;
                    if (cnt_q == LAST_WORD) state_d = FOOT;
                end
            end
            FOOT: begin
                out_valid = 1'b1;
                out_eop   = frame_end_q;
                out_data  = {16'h0000, checksum};
                if (out_ready) begin
                    state_d = frame_end_q ? IDLE : HDR;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign err_short_line = err_q;

`ifdef DSI_LINE_PKT_CRC_EN
    logic [15:0] crc_q;
    logic        crc_adv;

    // Bit-serial LSB-first update over the whole word, i.e. byte0..byte3.
    function automatic logic [15:0] crc_word(input logic [15:0] c, input logic [31:0] w);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 32; i++) r = (r[0] ^ w[i]) ? ((r >> 1) ^ 16'h8408) : (r >> 1);
        return r;
    endfunction

    assign crc_adv = out_ready && ((state_q == PAYLOAD && out_valid) || state_q == PAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) crc_q <= '0;
        else if (state_d == HDR && state_q != HDR) crc_q <= '1;
        else if (crc_adv) crc_q <= crc_word(crc_q, out_data);
    end

    assign checksum = crc_q;
`else
    assign checksum = 16'h0000;
`endif

endmodule
